// File: rtl/kp_pkg.sv
// Shared types for the keypoint drain controller: keypoint record layout,
// field widths and the controller state encoding.
package kp_pkg;
  localparam int X_W     = 10;
  localparam int Y_W     = 10;
  localparam int SCORE_W = 8;
  localparam int DESC_W  = 256;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [SCORE_W-1:0] score;
    logic [DESC_W-1:0]  desc;
  } kp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } kd_state_e;
endpackage

// File: rtl/key_drain_ctrl_if.sv
// Keypoint stream from the drain controller to the matcher.
// Handshake: a beat transfers on every clock edge where m_valid && m_ready.
// Once m_valid is raised, m_valid and all payload fields (m_x, m_y, m_score,
// m_desc, m_last) hold steady until that transfer; m_valid never depends on
// m_ready. m_last marks the final keypoint of a frame.
interface key_drain_ctrl_if;
  import kp_pkg::*;

  logic               m_valid;
  logic               m_ready;
  logic [X_W-1:0]     m_x;
  logic [Y_W-1:0]     m_y;
  logic [SCORE_W-1:0] m_score;
  logic [DESC_W-1:0]  m_desc;
  logic               m_last;

  modport master (output m_valid, m_x, m_y, m_score, m_desc, m_last, input m_ready);
  modport slave  (input m_valid, m_x, m_y, m_score, m_desc, m_last, output m_ready);
endinterface

// File: rtl/kp_out_stage.sv
// Single-entry valid/ready output register holding one keypoint and its
// end-of-frame marker. The parent only loads when o_can_load is high.
module kp_out_stage
  import kp_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  kp_t  i_kp,
  input  logic i_last,
  input  logic i_set_last,
  input  logic i_ready,
  output logic o_valid,
  output kp_t  o_kp,
  output logic o_last,
  output logic o_fire,
  output logic o_can_load
);
  assign o_fire     = o_valid & i_ready;
  assign o_can_load = ~o_valid | i_ready;

  // Slot register: load has priority, then drain on transfer, then late last-marking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_kp    <= '0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_kp    <= i_kp;
      o_last  <= i_last;
    end else if (o_fire) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (i_set_last && o_valid) begin
      o_last  <= 1'b1;
    end
  end
endmodule

// File: rtl/key_drain_ctrl.sv
// Frame-level controller for the top-K keypoint buffer: gates insertions
// during a frame, then drains the buffer head-first to the matcher stream.
module key_drain_ctrl
  import kp_pkg::*;
#(
  parameter int SIZE  = 100,
  parameter int CNT_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_start,
  input  logic               i_frame_end,
  input  logic               i_kp_valid,
  output logic               o_kp_ready,
  output logic               o_buf_valid,
  output logic               o_buf_next,
  input  logic               i_buf_flag,
  input  logic [X_W-1:0]     i_buf_x,
  input  logic [Y_W-1:0]     i_buf_y,
  input  logic [SCORE_W-1:0] i_buf_score,
  input  logic [DESC_W-1:0]  i_buf_desc,
  key_drain_ctrl_if.master   m_if,
  output logic               o_frame_done,
  output logic [CNT_W-1:0]   o_kp_count,
  output logic               o_overflow,
  output logic               o_busy,
  output kd_state_e          o_state
);
  kd_state_e        state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] remaining;
  logic             overflow;
  logic             frame_done;

  kp_t  head_kp;
  kp_t  slot_kp;
  logic slot_valid, slot_last, slot_fire, slot_can_load;
  logic do_insert, count_inc, do_load, no_head, drain_end;

  assign head_kp   = {i_buf_x, i_buf_y, i_buf_score, i_buf_desc};
  assign do_insert = (state == COLLECT) && i_kp_valid;
  // Once the buffer is full, inserts still reach it (rear slot replaced) but are not counted.
  assign count_inc = do_insert && (count < CNT_W'(SIZE));
  assign do_load   = (state == DRAIN) && (remaining != '0) && i_buf_flag && slot_can_load;
  // Buffer ran dry before the expected count: stop popping and close the frame early.
  assign no_head   = (state == DRAIN) && (remaining != '0) && !i_buf_flag;
  assign drain_end = (state == DRAIN) && ((remaining == '0) || !i_buf_flag)
                     && (!slot_valid || slot_fire);

  // Frame FSM with its counters; frame_done is registered so it pulses on entry to DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      count      <= '0;
      remaining  <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_frame_start) begin
            count    <= '0;
            overflow <= 1'b0;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (count_inc) begin
            count <= count + CNT_W'(1);
          end else if (do_insert) begin
            overflow <= 1'b1;
          end
          if (i_frame_end) begin
            remaining <= count_inc ? count + CNT_W'(1) : count;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (do_load) begin
            remaining <= remaining - CNT_W'(1);
          end else if (no_head) begin
            remaining <= '0;
          end
          if (drain_end) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  kp_out_stage u_out (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (do_load),
    .i_kp       (head_kp),
    .i_last     (remaining == CNT_W'(1)),
    .i_set_last (no_head),
    .i_ready    (m_if.m_ready),
    .o_valid    (slot_valid),
    .o_kp       (slot_kp),
    .o_last     (slot_last),
    .o_fire     (slot_fire),
    .o_can_load (slot_can_load)
  );

  assign m_if.m_valid = slot_valid;
  assign m_if.m_x     = slot_kp.x;
  assign m_if.m_y     = slot_kp.y;
  assign m_if.m_score = slot_kp.score;
  assign m_if.m_desc  = slot_kp.desc;
  assign m_if.m_last  = slot_last;

  assign o_kp_ready   = (state == COLLECT);
  assign o_buf_valid  = do_insert;
  assign o_buf_next   = do_load;
  assign o_frame_done = frame_done;
  assign o_kp_count   = count;
  assign o_overflow   = overflow;
  assign o_busy       = (state != IDLE);
  assign o_state      = state;
endmodule

// File: tb/tb_key_drain_ctrl.sv
// Bench for key_drain_ctrl: behavioural keypoint buffer, matcher scoreboard,
// a table of frame vectors, hand-written corner sequences and random frames.
module tb_key_drain_ctrl;
  import kp_pkg::*;

  localparam int SIZE  = 100;
  localparam int CNT_W = 10;
  localparam int BW    = $bits(kp_t) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic i_clk, i_rst;
  logic i_frame_start, i_frame_end, i_kp_valid;
  logic o_kp_ready, o_buf_valid, o_buf_next, i_buf_flag;
  logic o_frame_done, o_overflow, o_busy;
  logic [CNT_W-1:0] o_kp_count;
  kd_state_e o_state;
  kp_t fe_kp, buf_head;
  key_drain_ctrl_if m_if ();

  key_drain_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_frame_start (i_frame_start),
    .i_frame_end   (i_frame_end),
    .i_kp_valid    (i_kp_valid),
    .o_kp_ready    (o_kp_ready),
    .o_buf_valid   (o_buf_valid),
    .o_buf_next    (o_buf_next),
    .i_buf_flag    (i_buf_flag),
    .i_buf_x       (buf_head.x),
    .i_buf_y       (buf_head.y),
    .i_buf_score   (buf_head.score),
    .i_buf_desc    (buf_head.desc),
    .m_if          (m_if.master),
    .o_frame_done  (o_frame_done),
    .o_kp_count    (o_kp_count),
    .o_overflow    (o_overflow),
    .o_busy        (o_busy),
    .o_state       (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [BW:0] act, input logic [BW:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- behavioural keypoint buffer ----------------
  // FIFO head-first; when full, a new insert replaces the rear entry.
  kp_t buf_q[$];
  bit  pend_push, pend_pop;
  kp_t pend_kp;

  always @(negedge i_clk) begin
    pend_push = o_buf_valid;
    pend_pop  = o_buf_next;
    pend_kp   = fe_kp;
  end

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_q.delete();
      pend_push = 1'b0;
      pend_pop  = 1'b0;
    end else begin
      #1;
      if (pend_push) begin
        if (buf_q.size() >= SIZE) buf_q[SIZE-1] = pend_kp;
        else buf_q.push_back(pend_kp);
      end
      if (pend_pop && buf_q.size() > 0) void'(buf_q.pop_front());
    end
    i_buf_flag = (buf_q.size() > 0);
    buf_head   = i_buf_flag ? buf_q[0] : '0;
  end

  // ---------------- matcher ready driver ----------------
  int ready_pct;
  bit ready_pat_mode;
  bit ready_pat[$];

  always @(posedge i_clk) begin
    #1;
    if (!ready_pat_mode) m_if.m_ready = ($urandom_range(0, 99) < ready_pct);
    else if (m_if.m_valid) m_if.m_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] cur_beat, held_beat, exp_beat;
  bit hold_pending;
  int beats_seen, pops_seen, done_cyc;
  int beat_cyc[$];

  always @(negedge i_clk) begin
    cur_beat = {m_if.m_x, m_if.m_y, m_if.m_score, m_if.m_desc, m_if.m_last};
    if (i_rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("stall_hold", {m_if.m_valid, cur_beat}, {1'b1, held_beat});
      hold_pending = m_if.m_valid && !m_if.m_ready;
      held_beat    = cur_beat;
      if (m_if.m_valid && m_if.m_ready) begin
        beats_seen++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: unexpected beat %0h with no beat outstanding", cur_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", cur_beat, exp_beat);
        end
      end
      if (o_buf_next) pops_seen++;
      if (o_frame_done) done_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  // Beats expected from a frame: the first min(n,SIZE)-1 offered keypoints,
  // then the most recently offered one (it owns the rear slot); last flag on the final beat.
  kp_t offered[$];
  int  end_cyc, exp_k;
  bit  exp_ovf;

  task automatic model_frame();
    int  n = offered.size();
    int  k = (n < SIZE) ? n : SIZE;
    kp_t kept[$];
    for (int i = 0; i < k - 1; i++) kept.push_back(offered[i]);
    if (n > 0) kept.push_back(offered[n-1]);
    foreach (kept[i]) exp_q.push_back({kept[i], 1'(i == kept.size() - 1)});
    exp_k   = k;
    exp_ovf = (n > SIZE);
  endtask

  task automatic rand_kp(output kp_t k);
    k.x     = 10'($urandom_range(0, 1023));
    k.y     = 10'($urandom_range(0, 1023));
    k.score = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) k.desc[i*32 +: 32] = $urandom();
  endtask

  // ---------------- frame driver ----------------
  task automatic run_frame(input int n, input int gap_pct, input bit end_with_kp, input bit start_in_drain);
    bit done_hit;
    offered.delete();
    beat_cyc.delete();
    beats_seen = 0;
    pops_seen  = 0;
    done_cyc   = -1;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    @(negedge i_clk);
    check("kp_ready_collect", o_kp_ready, 1);
    check("busy_collect", o_busy, 1);
    step();
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) step();
      rand_kp(fe_kp);
      i_kp_valid = 1'b1;
      offered.push_back(fe_kp);
      if (end_with_kp && i == n - 1) begin
        i_frame_end = 1'b1;
        end_cyc = cyc;
      end
      step();
      i_kp_valid  = 1'b0;
      i_frame_end = 1'b0;
    end
    if (!(end_with_kp && n > 0)) begin
      i_frame_end = 1'b1;
      end_cyc = cyc;
      step();
      i_frame_end = 1'b0;
    end
    model_frame();
    if (start_in_drain) begin
      i_frame_start = 1'b1;
      step();
      i_frame_start = 1'b0;
    end
    done_hit = 1'b0;
    for (int c = 0; c < 3000 && !done_hit; c++) begin
      @(negedge i_clk);
      done_hit = o_frame_done;
    end
    if (!done_hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: no frame_done within 3000 cycles, %0d beats outstanding", exp_q.size());
      exp_q.delete();
    end else begin
      check("kp_count_done", o_kp_count, exp_k);
      check("overflow_done", o_overflow, exp_ovf);
    end
    step();
    @(negedge i_clk);
    check("done_pulse_width", o_frame_done, 0);
    check("busy_idle", o_busy, 0);
    check("count_hold_idle", o_kp_count, exp_k);
    check("beats", beats_seen, exp_k);
    check("pops", pops_seen, exp_k);
    check("exp_q_empty", exp_q.size(), 0);
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n;
    bit end_with_kp;
    int rdy_pct;
    int exp_count;
    bit exp_ovf;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5,   1'b0, 100, 5,   1'b0};
    vecs[1] = '{130, 1'b0, 100, 100, 1'b1};
    vecs[2] = '{0,   1'b0, 100, 0,   1'b0};
    vecs[3] = '{1,   1'b0, 60,  1,   1'b0};
    vecs[4] = '{99,  1'b0, 80,  99,  1'b0};
    vecs[5] = '{100, 1'b0, 100, 100, 1'b0};
    vecs[6] = '{101, 1'b1, 50,  100, 1'b1};
    vecs[7] = '{2,   1'b1, 100, 2,   1'b0};

    i_rst = 1'b1;
    i_frame_start = 1'b0;
    i_frame_end = 1'b0;
    i_kp_valid = 1'b0;
    fe_kp = '0;
    i_buf_flag = 1'b0;
    buf_head = '0;
    m_if.m_ready = 1'b0;
    ready_pct = 100;
    ready_pat_mode = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_m_valid", m_if.m_valid, 0);
    check("rst_m_data", {m_if.m_x, m_if.m_y, m_if.m_score, m_if.m_desc, m_if.m_last}, 0);
    check("rst_busy", o_busy, 0);
    check("rst_state", o_state, IDLE);
    check("rst_count", o_kp_count, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_kp_ready", o_kp_ready, 0);
    check("rst_buf_next", o_buf_next, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step();

    // table-driven frames
    for (int v = 0; v < 8; v++) begin
      ready_pct = vecs[v].rdy_pct;
      run_frame(vecs[v].n, 10, vecs[v].end_with_kp, 1'b0);
      check("tbl_count", o_kp_count, vecs[v].exp_count);
      check("tbl_overflow", o_overflow, vecs[v].exp_ovf);
      check("tbl_beats", beats_seen, vecs[v].exp_count);
    end

    // 5 keypoints at full ready: beats on consecutive cycles, done one cycle after the last
    ready_pct = 100;
    run_frame(5, 0, 1'b0, 1'b0);
    check("t1_nbeats", beat_cyc.size(), 5);
    if (beat_cyc.size() == 5) begin
      check("t1_first_beat", beat_cyc[0], end_cyc + 2);
      check("t1_last_beat", beat_cyc[4], end_cyc + 6);
    end
    check("t1_done", done_cyc, end_cyc + 7);

    // stall pattern 1,0,0,1 on ready
    ready_pat_mode = 1'b1;
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    m_if.m_ready = 1'b1;
    run_frame(3, 0, 1'b0, 1'b0);
    ready_pat_mode = 1'b0;
    check("t3_nbeats", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3) begin
      check("t3_beat1", beat_cyc[0], end_cyc + 2);
      check("t3_beat2", beat_cyc[1], end_cyc + 5);
      check("t3_beat3", beat_cyc[2], end_cyc + 6);
    end
    check("t3_pops", pops_seen, 3);

    // empty frame
    run_frame(0, 0, 1'b0, 1'b0);
    check("t4_done", done_cyc, end_cyc + 2);
    check("t4_beats", beats_seen, 0);

    // end together with the third keypoint; frame_start during drain ignored
    run_frame(3, 0, 1'b1, 1'b1);
    check("t5_count", o_kp_count, 3);
    check("t5_beats", beats_seen, 3);

    // reset in the middle of a drain
    ready_pct = 100;
    offered.delete();
    beat_cyc.delete();
    beats_seen = 0;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_kp(fe_kp);
      i_kp_valid = 1'b1;
      offered.push_back(fe_kp);
      step();
      i_kp_valid = 1'b0;
    end
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    model_frame();
    for (int c = 0; c < 50 && beats_seen < 2; c++) begin
      @(negedge i_clk);
      #2;
    end
    check("t6_beats_before_rst", beats_seen, 2);
    i_rst = 1'b1;
    #1;
    exp_q.delete();
    check("t6_m_valid", m_if.m_valid, 0);
    check("t6_m_data", {m_if.m_x, m_if.m_y, m_if.m_score, m_if.m_desc, m_if.m_last}, 0);
    check("t6_state", o_state, IDLE);
    check("t6_busy", o_busy, 0);
    check("t6_count", o_kp_count, 0);
    check("t6_buf_next", o_buf_next, 0);
    step();
    step();
    i_rst = 1'b0;
    step();
    run_frame(4, 0, 1'b0, 1'b0);
    check("t6_next_frame_count", o_kp_count, 4);

    // randomized frames against the model
    for (int r = 0; r < 12; r++) begin
      ready_pct = $urandom_range(30, 100);
      run_frame($urandom_range(0, 115), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
